mar_addr_scheduler: RTL
=======================

# mar_addr_scheduler

Address sequencer and MAR arbiter for the 2:1 image down-sampling datapath. It walks the destination image pixel by pixel. For each output pixel it issues four source-read addresses (the 2×2 neighbourhood) and one destination-write address by driving the MAR select and the read/write row/column registers. Between pixels it can grant the MAR to the processor's AC path. It sits between the control unit and the MAR, and paces itself on a completion pulse from the DRAM access logic.

## Interface
Parameters:
- SRC_DIM, 128: source image side in pixels. Must be even and ≤ 256.
- WR_ROW_BASE, 128: DRAM row at which the destination image starts. WR_ROW_BASE + SRC_DIM/2 must be ≤ 256.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- mem_done  in  1  one-cycle pulse: the current DRAM access has completed.
- ac_req  in  1  processor requests the MAR for an AC-sourced access.
- ac_gnt  out  1  grant to the AC path.
- mar_control  out  2  MAR select: 00 hold, 01 AC, 10 read regs, 11 write regs.
- rrr, crr  out  8 each  source read row and column.
- rwr, cwr  out  8 each  destination write row and column.
- tap  out  2  index (0..3) of the current read within the 2×2 group.
- busy  out  1  high from the first issue of a frame until DONE.
- done  out  1  one-cycle pulse when the frame completes.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, AC_ISSUE, AC_WAIT, DONE.
- Counters: r and c, each 0..OUT_DIM-1 where OUT_DIM = SRC_DIM/2. tap counts 0..3 as (dy,dx) = 00, 01, 10, 11.
- Read address: rrr = 2r + dy, crr = 2c + dx. Write address: rwr = WR_ROW_BASE + r, cwr = c. All are 8-bit; the parameter rules guarantee no overflow.
- mar_control is 00 in every state except the ISSUE states: RD_ISSUE → 10, WR_ISSUE → 11, AC_ISSUE → 01.
- RD_ISSUE → RD_WAIT. RD_WAIT waits for mem_done. On mem_done with tap < 3: tap += 1, go to RD_ISSUE. On mem_done with tap = 3: go to WR_ISSUE.
- WR_ISSUE → WR_WAIT. On mem_done in WR_WAIT:
  - Last pixel (r = c = OUT_DIM-1): go to DONE.
  - Otherwise: tap ← 0; c += 1, or c ← 0 and r += 1 on column wrap. Then go to the pixel boundary.
- Pixel boundary: if arbitration is compiled in, ac_req = 1, and no AC grant was given at the previous boundary, go to AC_ISSUE. Otherwise go to RD_ISSUE.
- In IDLE, ac_req = 1 has priority over start and goes to AC_ISSUE. After AC_WAIT, return to IDLE if no frame is active.
- AC_ISSUE → AC_WAIT. On mem_done, continue with RD_ISSUE of the pending pixel, or return to IDLE.
- ac_gnt is high throughout AC_ISSUE and AC_WAIT.
- DONE lasts one cycle: done = 1, counters cleared, → IDLE.
- mem_done is ignored in IDLE, DONE and every ISSUE state.
- start is ignored outside IDLE.

## Timing
- Reset (asynchronous, any time, including mid-frame): state IDLE, and all outputs 0 (mar_control = 00, all address outputs, tap, ac_gnt, busy, done). Counters are cleared and any in-flight access is abandoned.
- Address outputs are registered and are valid and stable from the ISSUE cycle until the next ISSUE. The MAR captures them at the rising edge that ends the ISSUE cycle.
- Start latency: start sampled at edge N gives RD_ISSUE (mar_control = 10, rrr = crr = 0) in cycle N+1.
- Throughput: with mem_done arriving the cycle after each ISSUE, a pixel takes 10 cycles. A full frame takes 10·OUT_DIM² cycles, plus 1 for DONE, plus 2 per AC grant.
- A mem_done that coincides with ac_req at a boundary is a simultaneous event. The boundary decision uses the ac_req value in the mem_done cycle.

## Configuration
- MAR_SCHED_AC_ARB_EN defined:
  - AC arbitration is active as described.
  - No more than one AC grant per pixel boundary, which bounds AC latency to one pixel time.
- MAR_SCHED_AC_ARB_EN undefined:
  - ac_req is ignored and ac_gnt is tied to 0.
  - AC_ISSUE and AC_WAIT are unreachable and mar_control never drives 01.

## Test plan
- SRC_DIM = 4, WR_ROW_BASE = 8, mem_done one cycle after each issue.
  - Required read sequence for pixel (0,0): (0,0), (0,1), (1,0), (1,1). Write to (8,0). Pixel (1,1) reads (2,2) .. (3,3) and writes (9,1).
  - done pulses at cycle 41 after start, busy then drops, outputs return to 0.
- mem_done delayed 5 cycles per access: rrr/crr/mar_control hold their values across the whole wait. A mem_done injected during RD_ISSUE has no effect.
- With arbitration compiled in, ac_req held high during a frame: exactly one AC grant between each pair of pixels (mar_control = 01, ac_gnt high until mem_done). The frame still completes with all 4 pixels correct.
- Same as the previous scenario with MAR_SCHED_AC_ARB_EN undefined: ac_gnt stays 0 and the frame timing is identical to the first scenario.
- reset_n pulsed low mid-WR_WAIT of pixel (0,1): outputs go to 0 immediately. A subsequent start restarts from pixel (0,0).
- start pulsed while busy: no effect, and the frame timing is unchanged.

Source files
------------

// File: rtl/mar_addr_scheduler_if.sv
// Handshake and MAR address bus between the address scheduler, the control
// unit, the DRAM access logic and the MAR.
interface mar_addr_scheduler_if;
  logic       start;
  logic       mem_done;
  logic       ac_req;
  logic       ac_gnt;
  logic [1:0] mar_control;
  logic [7:0] rrr;
  logic [7:0] crr;
  logic [7:0] rwr;
  logic [7:0] cwr;
  logic [1:0] tap;
  logic       busy;
  logic       done;

  modport master (
    input  start, mem_done, ac_req,
    output ac_gnt, mar_control, rrr, crr, rwr, cwr, tap, busy, done
  );

  modport slave (
    output start, mem_done, ac_req,
    input  ac_gnt, mar_control, rrr, crr, rwr, cwr, tap, busy, done
  );
endinterface

// File: rtl/mar_addr_scheduler.sv
// Address sequencer / MAR arbiter for 2:1 down-sampling: four 2x2 source reads
// then one destination write per output pixel. MAR_SCHED_AC_ARB_EN enables AC grants.
module mar_addr_scheduler #(
  parameter int SRC_DIM     = 128,
  parameter int WR_ROW_BASE = 128
) (
  input logic                    clock,
  input logic                    reset_n,
  mar_addr_scheduler_if.master   bus
);

  localparam int         OUT_DIM  = SRC_DIM / 2;
  localparam logic [7:0] LAST     = 8'(OUT_DIM - 1);
  localparam logic [7:0] ROW_BASE = 8'(WR_ROW_BASE);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, AC_ISSUE, AC_WAIT, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] r_q, r_d, c_q, c_d;
  logic [1:0] tap_q, tap_d;
  logic       active_q, active_d;
  logic [7:0] rrr_q, rrr_d, crr_q, crr_d, rwr_q, rwr_d, cwr_q, cwr_d;
  logic       ac_ok;

`ifdef MAR_SCHED_AC_ARB_EN
  assign ac_ok = bus.ac_req;
`else
  logic unused_ac_req;
  assign unused_ac_req = bus.ac_req;
  assign ac_ok         = 1'b0;
`endif

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    tap_d    = tap_q;
    active_d = active_q;
    rrr_d    = rrr_q;
    crr_d    = crr_q;
    rwr_d    = rwr_q;
    cwr_d    = cwr_q;

    case (state_q)
      IDLE: begin
        if (ac_ok) begin
          state_d = AC_ISSUE;
        end else if (bus.start) begin
          active_d = 1'b1;
          state_d  = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.mem_done) begin
          if (tap_q != 2'd3) begin
            tap_d   = tap_q + 2'd1;
            state_d = RD_ISSUE;
          end else begin
            state_d = WR_ISSUE;
          end
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.mem_done) begin
          if (r_q == LAST && c_q == LAST) begin
            state_d = DONE;
          end else begin
            tap_d = 2'd0;
            if (c_q == LAST) begin
              c_d = 8'd0;
              r_d = r_q + 8'd1;
            end else begin
              c_d = c_q + 8'd1;
            end
            // AC_WAIT always resumes reading, so a boundary grants AC at most once.
            state_d = ac_ok ? AC_ISSUE : RD_ISSUE;
          end
        end
      end
      AC_ISSUE: state_d = AC_WAIT;
      AC_WAIT: begin
        if (bus.mem_done) state_d = active_q ? RD_ISSUE : IDLE;
      end
      DONE: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address registers load only when entering an ISSUE state, so they stay
    // stable through the wait and any AC detour.
    if (state_d == RD_ISSUE) begin
      rrr_d = {r_d[6:0], tap_d[1]};
      crr_d = {c_d[6:0], tap_d[0]};
    end
    if (state_d == WR_ISSUE) begin
      rwr_d = ROW_BASE + r_d;
      cwr_d = c_d;
    end
    if (state_d == DONE) begin
      r_d   = 8'd0;
      c_d   = 8'd0;
      tap_d = 2'd0;
      rrr_d = 8'd0;
      crr_d = 8'd0;
      rwr_d = 8'd0;
      cwr_d = 8'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the asynchronous reset abandons any in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      r_q      <= 8'd0;
      c_q      <= 8'd0;
      tap_q    <= 2'd0;
      active_q <= 1'b0;
      rrr_q    <= 8'd0;
      crr_q    <= 8'd0;
      rwr_q    <= 8'd0;
      cwr_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      tap_q    <= tap_d;
      active_q <= active_d;
      rrr_q    <= rrr_d;
      crr_q    <= crr_d;
      rwr_q    <= rwr_d;
      cwr_q    <= cwr_d;
    end
  end

  always_comb begin
    bus.mar_control = 2'b00;
    case (state_q)
      RD_ISSUE: bus.mar_control = 2'b10;
      WR_ISSUE: bus.mar_control = 2'b11;
      AC_ISSUE: bus.mar_control = 2'b01;
      default:  bus.mar_control = 2'b00;
    endcase
  end

`ifdef MAR_SCHED_AC_ARB_EN
  assign bus.ac_gnt = (state_q == AC_ISSUE) || (state_q == AC_WAIT);
`else
  assign bus.ac_gnt = 1'b0;
`endif

  assign bus.rrr  = rrr_q;
  assign bus.crr  = crr_q;
  assign bus.rwr  = rwr_q;
  assign bus.cwr  = cwr_q;
  assign bus.tap  = tap_q;
  assign bus.busy = active_q;
  assign bus.done = (state_q == DONE);

endmodule
